divisor_sequencial8: RTL and testbench

- Sequential restoring divider. It is the responder side of the START/Pronto handshake that the RPN control path already uses for the multiplier.
- The control decoder pulses START with A and B valid, then waits for Pronto. It then loads Quociente/Resto into the result and remainder registers, and the error and remainder flags into their flag registers.
- Replaces the combinational divide path with a one-bit-per-cycle datapath.
- Sits beside the sequential multiplier under the RPN calculator top level.

---
 rtl/divisor_sequencial8.sv | 165 ++++++++++++++++
 tb/tb_divisor_sequencial8.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_sequencial8.sv
// Sequential restoring divider, one quotient bit per clock.
// Responder side of the START/Pronto handshake used by the RPN control path:
// the requester pulses START with A and B valid, then waits for Pronto and
// picks up Quociente, Resto, Erro and TemResto.
//
// state      | meaning
// -----------+------------------------------------------------------------
// OCIOSO     | idle after reset, waiting for START
// CALCULA    | one restoring step per edge, LARGURA steps in total
// DIV_ZERO   | divisor was 0; one-cycle pause before publishing the error
// CONCLUIDO  | results published, Pronto held; START here starts a new op
//
// DIV_ZERO keeps the divide-by-zero latency at one cycle (Pronto after the
// edge following acceptance) without raising Ocupado.
// LARGURA must be at least 2.

module divisor_sequencial8 #(
   parameter int LARGURA = 8
) (
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic               START,
   input  logic [LARGURA-1:0] A,
   input  logic [LARGURA-1:0] B,
   output logic [LARGURA-1:0] Quociente,
   output logic [LARGURA-1:0] Resto,
   output logic               Erro,
   output logic               TemResto,
   output logic               Ocupado,
   output logic               Pronto
);

   localparam int CNT_W = (LARGURA > 1) ? $clog2(LARGURA) : 1;
   localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(LARGURA - 1);

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      CALCULA   = 2'd1,
      DIV_ZERO  = 2'd2,
      CONCLUIDO = 2'd3
   } estado_t;

   estado_t            estado, estado_prox;

   // dividendo doubles as the quotient: dividend bits leave at the MSB while
   // quotient bits enter at the LSB.
   logic [LARGURA-1:0] dividendo, dividendo_prox;
   logic [LARGURA-1:0] divisor, divisor_prox;
   logic [LARGURA-1:0] parcial, parcial_prox;
   logic [CNT_W-1:0]   contador, contador_prox;

   logic [LARGURA-1:0] quociente_prox, resto_prox;
   logic               erro_prox, tem_resto_prox, ocupado_prox, pronto_prox;

   // One restoring step. The shifted partial remainder carries an extra bit
   // so the compare cannot overflow; after a successful subtract the result
   // is below the divisor, so the low LARGURA bits of the difference suffice.
   logic [LARGURA:0]   deslocado;
   logic               cabe;
   logic [LARGURA-1:0] subtraido;
   logic [LARGURA-1:0] parcial_passo;
   logic [LARGURA-1:0] quociente_passo;

   // Datapath for a single restoring iteration.
   always_comb begin
      deslocado       = {parcial, dividendo[LARGURA-1]};
      cabe            = (deslocado >= {1'b0, divisor});
      subtraido       = deslocado[LARGURA-1:0] - divisor;
      parcial_passo   = cabe ? subtraido : deslocado[LARGURA-1:0];
      quociente_passo = {dividendo[LARGURA-2:0], cabe};
   end

   // Next-state and next-output logic; everything holds unless changed.
   always_comb begin
      estado_prox    = estado;
      dividendo_prox = dividendo;
      divisor_prox   = divisor;
      parcial_prox   = parcial;
      contador_prox  = contador;
      quociente_prox = Quociente;
      resto_prox     = Resto;
      erro_prox      = Erro;
      tem_resto_prox = TemResto;
      ocupado_prox   = Ocupado;
      pronto_prox    = Pronto;

      unique case (estado)
         OCIOSO, CONCLUIDO: begin
            if (START) begin
               dividendo_prox = A;
               divisor_prox   = B;
               parcial_prox   = '0;
               contador_prox  = '0;
               pronto_prox    = 1'b0;
               if (B == '0) begin
                  estado_prox  = DIV_ZERO;
                  ocupado_prox = 1'b0;
               end else begin
                  estado_prox  = CALCULA;
                  ocupado_prox = 1'b1;
               end
            end
         end

         CALCULA: begin
            parcial_prox   = parcial_passo;
            dividendo_prox = quociente_passo;
            contador_prox  = contador + CNT_W'(1);
            if (contador == ULTIMO) begin
               estado_prox    = CONCLUIDO;
               quociente_prox = quociente_passo;
               resto_prox     = parcial_passo;
               erro_prox      = 1'b0;
               tem_resto_prox = (parcial_passo != '0);
               ocupado_prox   = 1'b0;
               pronto_prox    = 1'b1;
            end
         end

         DIV_ZERO: begin
            estado_prox    = CONCLUIDO;
            quociente_prox = '0;
            resto_prox     = dividendo;
            erro_prox      = 1'b1;
            tem_resto_prox = (dividendo != '0);
            ocupado_prox   = 1'b0;
            pronto_prox    = 1'b1;
         end

         default: begin
            estado_prox = OCIOSO;
         end
      endcase
   end

   // State, working registers and published outputs; reset drops everything.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         estado    <= OCIOSO;
         dividendo <= '0;
         divisor   <= '0;
         parcial   <= '0;
         contador  <= '0;
         Quociente <= '0;
         Resto     <= '0;
         Erro      <= 1'b0;
         TemResto  <= 1'b0;
         Ocupado   <= 1'b0;
         Pronto    <= 1'b0;
      end else begin
         estado    <= estado_prox;
         dividendo <= dividendo_prox;
         divisor   <= divisor_prox;
         parcial   <= parcial_prox;
         contador  <= contador_prox;
         Quociente <= quociente_prox;
         Resto     <= resto_prox;
         Erro      <= erro_prox;
         TemResto  <= tem_resto_prox;
         Ocupado   <= ocupado_prox;
         Pronto    <= pronto_prox;
      end
   end

endmodule

// File: tb/tb_divisor_sequencial8.sv
// Directed bench for the sequential divider: handshake timing, result values,
// divide-by-zero, START while busy, asynchronous reset and back-to-back use.

module tb_divisor_sequencial8;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b0;
   logic       START = 1'b0;
   logic [7:0] A = 8'd0;
   logic [7:0] B = 8'd0;
   logic [7:0] Quociente, Resto;
   logic       Erro, TemResto, Ocupado, Pronto;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] last_q = 8'd0;
   logic [7:0] last_r = 8'd0;
   logic       last_e = 1'b0;
   logic       last_t = 1'b0;

   divisor_sequencial8 #(.LARGURA(8)) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .START     (START),
      .A         (A),
      .B         (B),
      .Quociente (Quociente),
      .Resto     (Resto),
      .Erro      (Erro),
      .TemResto  (TemResto),
      .Ocupado   (Ocupado),
      .Pronto    (Pronto)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_q"},  32'(Quociente), 32'd0);
      chk({tag, "_r"},  32'(Resto),     32'd0);
      chk({tag, "_e"},  32'(Erro),      32'd0);
      chk({tag, "_t"},  32'(TemResto),  32'd0);
      chk({tag, "_oc"}, 32'(Ocupado),   32'd0);
      chk({tag, "_pr"}, 32'(Pronto),    32'd0);
   endtask

   // One full operation: one-cycle START, inputs scrambled afterwards,
   // outputs must hold until Pronto, then carry the expected result.
   task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ee);
      int cyc;
      int lat;
      lat = (b == 8'd0) ? 1 : 8;
      A = a;
      B = b;
      START = 1'b1;
      tick();
      START = 1'b0;
      A = 8'($urandom);
      B = 8'($urandom);
      chk({tag, "_hold_q"}, 32'(Quociente), 32'(last_q));
      chk({tag, "_hold_r"}, 32'(Resto),     32'(last_r));
      chk({tag, "_hold_e"}, 32'(Erro),      32'(last_e));
      chk({tag, "_hold_t"}, 32'(TemResto),  32'(last_t));
      chk({tag, "_pr_low"}, 32'(Pronto),    32'd0);
      cyc = 0;
      while (Pronto !== 1'b1 && cyc < 30) begin
         chk({tag, "_busy"}, 32'(Ocupado), 32'(b != 8'd0));
         tick();
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc),      32'(lat));
      chk({tag, "_q"},       32'(Quociente), 32'(eq));
      chk({tag, "_r"},       32'(Resto),     32'(er));
      chk({tag, "_e"},       32'(Erro),      32'(ee));
      chk({tag, "_t"},       32'(TemResto),  32'(er != 8'd0));
      chk({tag, "_oc_end"},  32'(Ocupado),   32'd0);
      tick();
      chk({tag, "_pr_held"}, 32'(Pronto),    32'd1);
      chk({tag, "_q_held"},  32'(Quociente), 32'(eq));
      last_q = eq;
      last_r = er;
      last_e = ee;
      last_t = (er != 8'd0);
   endtask

   initial begin
      int cyc;
      int seen;
      int pulses;
      int last_edge;
      logic prev_p;
      logic [7:0] ra, rb;

      // Reset state
      tick();
      tick();
      chk_all_zero("reset");
      @(negedge CLOCK);
      RESET = 1'b1;
      repeat (3) tick();
      chk("idle_no_pronto", 32'(Pronto), 32'd0);
      chk("idle_no_busy",   32'(Ocupado), 32'd0);

      // Directed operations
      run_div("d200_7", 8'd200, 8'd7,  8'd28,  8'd4, 1'b0);
      run_div("d255_1", 8'd255, 8'd1,  8'd255, 8'd0, 1'b0);
      run_div("d3_10",  8'd3,   8'd10, 8'd0,   8'd3, 1'b0);
      run_div("d5_0",   8'd5,   8'd0,  8'd0,   8'd5, 1'b1);
      run_div("d9_3",   8'd9,   8'd3,  8'd3,   8'd0, 1'b0);
      run_div("d0_0",   8'd0,   8'd0,  8'd0,   8'd0, 1'b1);
      run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
      run_div("d254_255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0);

      // START and operand changes while busy are ignored
      A = 8'd100;
      B = 8'd9;
      START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      tick();
      START = 1'b1;
      A = 8'd1;
      B = 8'd1;
      tick();
      START = 1'b0;
      A = 8'd0;
      B = 8'd0;
      cyc = 3;
      while (Pronto !== 1'b1 && cyc < 30) begin
         tick();
         cyc++;
      end
      chk("busy_start_latency", 32'(cyc),       32'd8);
      chk("busy_start_q",       32'(Quociente), 32'd11);
      chk("busy_start_r",       32'(Resto),     32'd1);
      chk("busy_start_t",       32'(TemResto),  32'd1);
      chk("busy_start_e",       32'(Erro),      32'd0);
      last_q = 8'd11;
      last_r = 8'd1;
      last_e = 1'b0;
      last_t = 1'b1;

      // Asynchronous reset in the middle of CALCULA
      A = 8'd100;
      B = 8'd9;
      START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      tick();
      #2;
      RESET = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(negedge CLOCK);
      RESET = 1'b1;
      last_q = 8'd0;
      last_r = 8'd0;
      last_e = 1'b0;
      last_t = 1'b0;
      seen = 0;
      repeat (12) begin
         tick();
         if (Pronto === 1'b1 || Ocupado === 1'b1) seen++;
      end
      chk("rst_no_activity", 32'(seen), 32'd0);
      run_div("d50_6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0);

      // START held high: one-cycle Pronto every 9 cycles
      A = 8'd17;
      B = 8'd4;
      START = 1'b1;
      prev_p = 1'b0;
      last_edge = -1;
      pulses = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (Pronto === 1'b1) begin
            pulses++;
            chk("b2b_width", 32'(prev_p), 32'd0);
            if (last_edge >= 0) chk("b2b_period", 32'(c - last_edge), 32'd9);
            chk("b2b_q", 32'(Quociente), 32'd4);
            chk("b2b_r", 32'(Resto),     32'd1);
            last_edge = c;
         end
         prev_p = Pronto;
      end
      chk("b2b_pulses", 32'(pulses), 32'd4);
      START = 1'b0;
      cyc = 0;
      while (Pronto !== 1'b1 && cyc < 30) begin
         tick();
         cyc++;
      end
      chk("b2b_drain", 32'(Pronto), 32'd1);
      last_q = 8'd4;
      last_r = 8'd1;
      last_e = 1'b0;
      last_t = 1'b1;

      // Random sweep against the arithmetic reference
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom_range(255, 1));
         run_div("rnd", ra, rb, ra / rb, ra % rb, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d, failures %0d", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
